cpu_clk_ctrl: RTL and testbench
===============================

Name: cpu_clk_ctrl

Overview:
- Run/step/halt controller for the single-cycle CPU's clock enable on the FPGA board.
- Sits between the board switch/button inputs and the CPU's clock enable.
- Issues one-cycle `cpu_en` pulses: at a divided rate in run mode, or one per debounced button press in step mode.
- Stops issuing pulses when the CPU raises a halt request. Counts retired cycles for display.

Parameters:
TICK_DIV, 50_000, clk cycles between cpu_en pulses in RUN (>=2)
DB_CYCLES, 1_000_000, consecutive stable synchronized cycles required to accept a step_btn level change (>=2)

Ports:
clk  input  1  system clock
clr  input  1  reset, asynchronous, active-high
run_sw  input  1  raw run switch (level, asynchronous to clk)
step_btn  input  1  raw step push-button (bouncy, asynchronous)
halt_req  input  1  CPU halt request (synchronous to clk, level)
cpu_en  output  1  registered one-cycle clock-enable pulse to CPU
state  output  2  current FSM state (IDLE=00, RUN=01, STEP=10, HALT=11)
cycle_count  output  32  number of cpu_en pulses issued since reset
busy  output  1  1 when state is RUN or STEP

Behaviour:
- Reset (clr=1, asynchronous):
  - state=IDLE, cpu_en=0, cycle_count=0.
  - Tick counter=0, debounce counter=0, stable button level=0, synchronizer flops=0.
  - A button held through reset is accepted as a press after DB_CYCLES.
- Synchronizers: run_sw and step_btn each pass through 2 flops; run_s and btn_s are the second-flop outputs.
- Debounce:
  - If btn_s equals the stable level, the debounce counter clears.
  - Otherwise it increments. When it reaches DB_CYCLES-1 while still differing, the stable level takes btn_s and the counter clears.
  - step_pulse = 1 for exactly one cycle when the stable level goes 0->1. Release generates nothing.
- Tick counter:
  - Counts 0..TICK_DIV-1 only while state=RUN. tick = (RUN and counter==TICK_DIV-1), after which the counter wraps to 0.
  - Forced to 0 in every non-RUN state, so each RUN entry starts a fresh full period.
- FSM transitions are evaluated each cycle, priority top-down:
  - Any state except HALT: halt_req=1 -> HALT.
  - IDLE: run_s=1 -> RUN; else step_pulse -> STEP; else stay. step_pulse while run_s=1 is ignored.
  - RUN: run_s=0 -> IDLE; else tick -> RUN with cpu_en=1 next cycle.
  - STEP: unconditionally -> IDLE next cycle.
  - HALT: stays until clr, or until step_pulse while run_s=0 -> IDLE (operator acknowledge; no cpu_en issued).
- cpu_en is registered and asserted:
  - the cycle after tick (if no halt_req in the tick cycle and run_s=1), or
  - in the single cycle the FSM is in STEP.
  - Never two consecutive cycles except for TICK_DIV edge cases; TICK_DIV>=2 guarantees gaps.
- Latency:
  - step_pulse at cycle n -> state=STEP and cpu_en=1 at n+1 -> IDLE at n+2.
  - RUN entered at cycle m -> first cpu_en at m+TICK_DIV.
- Simultaneous events:
  - halt_req with tick: HALT, no pulse.
  - halt_req in IDLE with step_pulse: HALT, no pulse.
  - run_s falling with tick: IDLE, no pulse.
- cycle_count increments by 1 in the cycle cpu_en=1 (registered alongside it), wrapping from 0xFFFF_FFFF to 0.
- Reset mid-operation aborts any pending pulse immediately; cpu_en drops asynchronously.

Test Plan:
1. TICK_DIV=4, DB_CYCLES=3; reset, run_sw=1 for 40 cycles -> state=RUN 3 cycles after run_sw (2 sync + 1); cpu_en pulses every 4 cycles, first at RUN entry+4; cycle_count counts each pulse; run_sw=0 -> IDLE, pulses stop.
2. step_btn bounce pattern 1,0,1,0 then held 1 for 10 cycles -> exactly one cpu_en pulse, 2+3+1 cycles after the stable high begins; cycle_count=1; release then no pulse.
3. RUN with halt_req=1 coincident with tick -> state=HALT next cycle, no cpu_en, cycle_count unchanged; further ticks/steps with run_sw=1 ignored; run_sw=0 plus step press -> IDLE, cycle_count unchanged.
4. clr pulsed mid-RUN, with tick counter=2 and cycle_count=5 -> immediately state=00, cpu_en=0, cycle_count=0; after release with run_sw=1 held, first pulse again TICK_DIV cycles after RUN entry.
5. Force cycle_count to 0xFFFF_FFFF (via repeated steps or a bench backdoor), issue one step -> cycle_count=0, cpu_en=1 for one cycle.
6. step_btn held high across clr release -> one step pulse after 2+DB_CYCLES cycles, state sequence IDLE->STEP->IDLE.

Source files
------------

// File: rtl/cpu_clk_ctrl.sv
// Run/step/halt clock-enable controller for the single-cycle CPU.
// Emits one-cycle cpu_en pulses from a divided tick (RUN) or a debounced button (STEP).
module cpu_clk_ctrl #(
  parameter int TICK_DIV  = 50_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        run_sw,
  input  logic        step_btn,
  input  logic        halt_req,
  output logic        cpu_en,
  output logic [1:0]  state,
  output logic [31:0] cycle_count,
  output logic        busy
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] STEP = 2'b10;
  localparam logic [1:0] HALT = 2'b11;

  localparam int TW  = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);

  logic run_m, run_s, btn_m, btn_s;
  logic btn_stable, step_pulse;
  logic [DBW-1:0] db_cnt;
  logic [TW-1:0]  tick_cnt;
  logic tick;
  logic [1:0] next_state;
  logic en_next;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      run_m <= 1'b0;
      run_s <= 1'b0;
      btn_m <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      run_m <= run_sw;
      run_s <= run_m;
      btn_m <= step_btn;
      btn_s <= btn_m;
    end
  end

  // A level change is accepted only after DB_CYCLES consecutive differing samples.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      db_cnt     <= '0;
      btn_stable <= 1'b0;
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      if (btn_s == btn_stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt     <= '0;
        btn_stable <= btn_s;
        step_pulse <= btn_s;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign tick = (state == RUN) && (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      tick_cnt <= '0;
    end else if (state != RUN || tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    en_next    = 1'b0;
    case (state)
      IDLE: begin
        if (halt_req)        next_state = HALT;
        else if (run_s)      next_state = RUN;
        else if (step_pulse) next_state = STEP;
      end
      RUN: begin
        if (halt_req)    next_state = HALT;
        else if (!run_s) next_state = IDLE;
        else             en_next    = tick;
      end
      STEP: begin
        if (halt_req) next_state = HALT;
        else          next_state = IDLE;
      end
      default: begin
        // Operator acknowledge: only a step press with the run switch off leaves HALT.
        if (step_pulse && !run_s) next_state = IDLE;
      end
    endcase
    if (next_state == STEP) en_next = 1'b1;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state       <= IDLE;
      cpu_en      <= 1'b0;
      cycle_count <= '0;
    end else begin
      state  <= next_state;
      cpu_en <= en_next;
      if (en_next) cycle_count <= cycle_count + 32'd1;
    end
  end

  assign busy = (state == RUN) || (state == STEP);

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed bench for cpu_clk_ctrl with TICK_DIV=4, DB_CYCLES=3.
module tb_cpu_clk_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic        run_sw;
  logic        step_btn;
  logic        halt_req;
  logic        cpu_en;
  logic [1:0]  state;
  logic [31:0] cycle_count;
  logic        busy;

  int vectors = 0;
  int errs    = 0;

  cpu_clk_ctrl #(.TICK_DIV(4), .DB_CYCLES(3)) dut (
    .clk(clk), .clr(clr), .run_sw(run_sw), .step_btn(step_btn), .halt_req(halt_req),
    .cpu_en(cpu_en), .state(state), .cycle_count(cycle_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    clr = 1'b1; run_sw = 1'b0; step_btn = 1'b0; halt_req = 1'b0;
    #2;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_en", 32'(cpu_en), 32'd0);
    chk("rst_count", cycle_count, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    cyc(2);
    clr = 1'b0;
    cyc(1);

    // Run mode: RUN three edges after the switch, pulses every 4 cycles.
    run_sw = 1'b1;
    cyc(2);
    chk("run_sync_idle", 32'(state), 32'd0);
    cyc(1);
    chk("run_entry", 32'(state), 32'd1);
    chk("run_busy", 32'(busy), 32'd1);
    cyc(3);
    chk("run_no_early_en", 32'(cpu_en), 32'd0);
    cyc(1);
    chk("run_first_en", 32'(cpu_en), 32'd1);
    chk("run_count1", cycle_count, 32'd1);
    cyc(1);
    chk("run_en_one_cycle", 32'(cpu_en), 32'd0);
    cyc(3);
    chk("run_second_en", 32'(cpu_en), 32'd1);
    chk("run_count2", cycle_count, 32'd2);
    for (int k = 3; k <= 6; k++) begin
      cyc(4);
      chk("run_periodic_en", 32'(cpu_en), 32'd1);
      chk("run_periodic_count", cycle_count, 32'(k));
    end
    run_sw = 1'b0;
    cyc(3);
    chk("run_off_idle", 32'(state), 32'd0);
    cyc(8);
    chk("run_off_no_en", 32'(cpu_en), 32'd0);
    chk("run_off_count", cycle_count, 32'd6);

    // Bouncy button: only the stable high produces a single step.
    step_btn = 1'b1; cyc(1);
    step_btn = 1'b0; cyc(1);
    step_btn = 1'b1; cyc(1);
    step_btn = 1'b0; cyc(1);
    step_btn = 1'b1;
    cyc(5);
    chk("step_wait_idle", 32'(state), 32'd0);
    chk("step_wait_no_en", 32'(cpu_en), 32'd0);
    cyc(1);
    chk("step_state", 32'(state), 32'd2);
    chk("step_en", 32'(cpu_en), 32'd1);
    chk("step_count", cycle_count, 32'd7);
    chk("step_busy", 32'(busy), 32'd1);
    cyc(1);
    chk("step_back_idle", 32'(state), 32'd0);
    chk("step_en_drop", 32'(cpu_en), 32'd0);
    cyc(5);
    step_btn = 1'b0;
    cyc(10);
    chk("release_no_step", 32'(state), 32'd0);
    chk("release_count", cycle_count, 32'd7);

    // halt_req coincident with the tick cycle.
    run_sw = 1'b1;
    cyc(6);
    chk("halt_pre_state", 32'(state), 32'd1);
    halt_req = 1'b1;
    cyc(1);
    halt_req = 1'b0;
    chk("halt_state", 32'(state), 32'd3);
    chk("halt_no_en", 32'(cpu_en), 32'd0);
    chk("halt_count", cycle_count, 32'd7);
    chk("halt_busy", 32'(busy), 32'd0);
    cyc(8);
    chk("halt_sticky", 32'(state), 32'd3);
    step_btn = 1'b1;
    cyc(8);
    chk("halt_step_run_on", 32'(state), 32'd3);
    chk("halt_step_run_on_en", 32'(cpu_en), 32'd0);
    step_btn = 1'b0;
    cyc(8);
    run_sw = 1'b0;
    cyc(4);
    step_btn = 1'b1;
    cyc(5);
    chk("ack_wait", 32'(state), 32'd3);
    cyc(1);
    chk("ack_idle", 32'(state), 32'd0);
    chk("ack_no_en", 32'(cpu_en), 32'd0);
    chk("ack_count", cycle_count, 32'd7);
    step_btn = 1'b0;
    cyc(8);

    // Asynchronous clear while a pulse is being issued.
    run_sw = 1'b1;
    cyc(7);
    chk("pre_clr_en", 32'(cpu_en), 32'd1);
    chk("pre_clr_count", cycle_count, 32'd8);
    clr = 1'b1;
    #1;
    chk("clr_async_en", 32'(cpu_en), 32'd0);
    chk("clr_async_state", 32'(state), 32'd0);
    chk("clr_async_count", cycle_count, 32'd0);
    cyc(1);
    clr = 1'b0;
    cyc(3);
    chk("post_clr_run", 32'(state), 32'd1);
    cyc(3);
    chk("post_clr_no_en", 32'(cpu_en), 32'd0);
    cyc(1);
    chk("post_clr_first_en", 32'(cpu_en), 32'd1);
    chk("post_clr_count", cycle_count, 32'd1);
    run_sw = 1'b0;
    cyc(6);
    chk("post_clr_idle", 32'(state), 32'd0);

    // Counter wrap from all-ones.
    force dut.cycle_count = 32'hFFFF_FFFF;
    cyc(1);
    release dut.cycle_count;
    cyc(1);
    chk("wrap_preset", cycle_count, 32'hFFFF_FFFF);
    step_btn = 1'b1;
    cyc(6);
    chk("wrap_en", 32'(cpu_en), 32'd1);
    chk("wrap_count", cycle_count, 32'd0);
    cyc(1);
    chk("wrap_en_drop", 32'(cpu_en), 32'd0);
    step_btn = 1'b0;
    cyc(8);

    // Button held through reset is taken as a press after release.
    step_btn = 1'b1;
    clr = 1'b1;
    cyc(2);
    clr = 1'b0;
    cyc(5);
    chk("held_wait_idle", 32'(state), 32'd0);
    cyc(1);
    chk("held_step_state", 32'(state), 32'd2);
    chk("held_step_en", 32'(cpu_en), 32'd1);
    chk("held_step_count", cycle_count, 32'd1);
    cyc(1);
    chk("held_back_idle", 32'(state), 32'd0);
    step_btn = 1'b0;
    cyc(8);

    // halt_req in IDLE together with step_pulse wins.
    step_btn = 1'b1;
    cyc(5);
    halt_req = 1'b1;
    cyc(1);
    halt_req = 1'b0;
    chk("halt_vs_step_state", 32'(state), 32'd3);
    chk("halt_vs_step_en", 32'(cpu_en), 32'd0);
    chk("halt_vs_step_count", cycle_count, 32'd1);
    step_btn = 1'b0;
    cyc(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
